// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
// State encodings and the one-hot helper are used by reg_write_arbiter.
package reg_arb_pkg;

    // Widest requester vector the one-hot helper can produce.
    localparam int unsigned REQ_MAX = 32;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_GRANT = 2'd1;
    localparam logic [1:0] ENC_ACK   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_GRANT = ENC_GRANT,
        ST_ACK   = ENC_ACK
    } state_t;

    function automatic logic [REQ_MAX-1:0] onehot(input int unsigned idx);
        return REQ_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr_i, searching cyclically, plus a flag saying any request is set.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [PTR_W-1:0]   winner_o
);

    // Scan from the farthest offset down so the nearest one to ptr_i wins.
    always_comb begin
        int unsigned idx;
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (32'(ptr_i) + 32'(i)) % NUM_REQ;
            if (req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one n-bit register among NUM_REQ writers via
// req/grant/ack. Optional REG_ARB_LOCK_EN adds a lock port for back-to-back writes.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int n       = 4,
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    // Handshake: a requester holds req high until it sees its one-cycle ack,
    // and drops req in that ack cycle or it competes again from IDLE.
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*n-1:0] data,
`ifdef REG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   lock,
`endif
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 busy,
    output logic [n-1:0]         Q
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W-1:0]   win_q;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_win;
    logic [n-1:0]       words [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_words
        assign words[k] = data[k*n +: n];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .winner_o (pick_win)
    );

    // Pointer moves just past the winner, wrapping for non-power-of-two counts.
    always_comb begin
        ptr_d = '0;
        if (pick_win != PTR_W'(NUM_REQ - 1)) begin
            ptr_d = pick_win + PTR_W'(1);
        end
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            grant   <= '0;
            ack     <= '0;
            Q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ST_GRANT;
                        win_q   <= pick_win;
                        ptr_q   <= ptr_d;
                        grant   <= NUM_REQ'(onehot(32'(pick_win)));
                    end
                end
                ST_GRANT: begin
                    // req is deliberately not re-checked: a grant always completes.
                    Q       <= words[win_q];
                    grant   <= '0;
                    ack     <= NUM_REQ'(onehot(32'(win_q)));
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    ack <= '0;
`ifdef REG_ARB_LOCK_EN
                    if (lock[win_q] && req[win_q]) begin
                        state_q <= ST_GRANT;
                        grant   <= NUM_REQ'(onehot(32'(win_q)));
                    end else begin
                        state_q <= ST_IDLE;
                    end
`else
                    state_q <= ST_IDLE;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    a_grant_ack_excl: assert property (@(posedge clk) disable iff (reset)
        !((|grant) && (|ack)));
    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant));
    a_ack_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(ack));

endmodule
